pipe_stage_reg: RTL

//   Generic parametrised pipeline stage register replacing fixed-field latches (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 19 +
 rtl/pipe_data_slot.sv | 28 ++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register and the
// per-stage wrappers that pack named fields into its payload.
package pipe_stage_reg_pkg;

  // Occupancy of the stage: main entry only, or main plus skid entry.
  typedef enum logic [1:0] {
    PS_EMPTY   = 2'd0,
    PS_FULL    = 2'd1,
    PS_SKIDDED = 2'd2
  } ps_state_e;

  // EX/MEM payload layout used by the EX/MEM wrapper.
  localparam int EXMEM_WIDTH          = 285;
  localparam int EXMEM_PC_ADD_LSB     = 0;
  localparam int EXMEM_PC_ADD_W       = 32;
  localparam int EXMEM_MEM_DATA_W_LSB = 283;
  localparam int EXMEM_MEM_DATA_W_W   = 2;

endpackage

// File: rtl/pipe_data_slot.sv
// One payload entry of a pipeline stage: WIDTH-bit register with load
// enable, updated on the falling clock edge, async reset to RESET_VALUE.
module pipe_data_slot #(
  parameter int               WIDTH       = 285,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Capture d on load; otherwise hold.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (load) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: one WIDTH-bit payload with valid/ready
// flow control, flush to a bubble, optional skid entry so in_ready comes
// straight from state flops, and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH        = 285,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
  parameter bit               SKID         = 1'b1,
  parameter int               STALL_CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [STALL_CNT_W-1:0] stall_count
);

  ps_state_e              state_q, state_d;
  logic                   in_fire, out_fire;
  logic                   main_load, skid_load;
  logic [WIDTH-1:0]       main_d, skid_d, skid_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign out_valid = (state_q != PS_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Ready to upstream: decoded from state with a skid entry, otherwise
  // passes the downstream ready through.
  generate
    if (SKID) begin : g_ready_reg
      assign in_ready = (state_q != PS_SKIDDED);
    end else begin : g_ready_comb
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next occupancy and which entry loads what; flush overrides everything.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latches).
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_data;
    skid_load = 1'b0;
    skid_d    = in_data;
    if (flush) begin
      state_d   = PS_EMPTY;
      main_load = 1'b1;
      main_d    = BUBBLE_VALUE;
      skid_load = 1'b1;
      skid_d    = BUBBLE_VALUE;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d   = PS_FULL;
            main_load = 1'b1;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            // Back-to-back refill, or drain leaving stale data in main.
            main_load = in_fire;
            state_d   = in_fire ? PS_FULL : PS_EMPTY;
          end else if (in_fire) begin
            // Only reachable with a skid entry: in_ready is 0 here otherwise.
            state_d   = PS_SKIDDED;
            skid_load = 1'b1;
          end
        end
        PS_SKIDDED: begin
          if (out_fire) begin
            state_d   = PS_FULL;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  // Saturating count of edges where downstream holds off a valid payload.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Occupancy and stall counter flops, falling-edge like every stage latch.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= PS_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

  pipe_data_slot #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_main (
    .clock(clock),
    .reset(reset),
    .load (main_load),
    .d    (main_d),
    .q    (out_data)
  );

  // Skid entry exists only when in_ready must come from flops.
  generate
    if (SKID) begin : g_skid
      pipe_data_slot #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
      ) u_skid (
        .clock(clock),
        .reset(reset),
        .load (skid_load),
        .d    (skid_d),
        .q    (skid_q)
      );
    end else begin : g_no_skid
      logic unused_skid;
      assign skid_q      = RESET_VALUE;
      assign unused_skid = ^{skid_load, skid_d};
    end
  endgenerate

endmodule
